// File: rtl/uart_io_regs.sv
// uart_io_regs: CPU memory-mapped UART peripheral.
//   Buffers CPU TX bytes and drains them into the UART loop
//   (uart_io_char/uart_io_we, back-pressured by uart_io_full). Captures received
//   chars (rout/rout_en) into an RX FIFO while the CPU runs. Owns uart_term.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   io_we/io_wadr/io_wdata     CPU write port (word address [15:2])
//   io_re/io_radr/io_rdata     CPU read port, one-cycle latency, 0 when no hit
//   cpu_run_state              gates RX capture
//   rout_en/rout               received char stream
//   uart_io_char/uart_io_we    TX char to UART loop; uart_io_full back-pressure
//   uart_term                  baud term
//   rx_irq                     level RX interrupt
// Optional: define UART_IO_LOOPBACK_EN to make CTRL bit2 a TX->RX loopback.
module uart_io_regs #(
  parameter logic [13:0] ADR_BASE     = 14'h3E00,
  parameter int          TX_DEPTH_LOG = 2,
  parameter int          RX_DEPTH_LOG = 3,
  parameter logic [15:0] TERM_DEF     = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_we,
  input  logic [13:0] io_wadr,
  input  logic [31:0] io_wdata,
  input  logic        io_re,
  input  logic [13:0] io_radr,
  output logic [31:0] io_rdata,
  input  logic        cpu_run_state,
  input  logic        rout_en,
  input  logic [7:0]  rout,
  output logic [7:0]  uart_io_char,
  output logic        uart_io_we,
  input  logic        uart_io_full,
  output logic [15:0] uart_term,
  output logic        rx_irq
);
  localparam int TXD = 1 << TX_DEPTH_LOG;
  localparam int RXD = 1 << RX_DEPTH_LOG;

  logic [TX_DEPTH_LOG:0]     tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [RX_DEPTH_LOG:0]     rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [TXD-1:0][7:0]       tx_mem_q, tx_mem_d;
  logic [RXD-1:0][7:0]       rx_mem_q, rx_mem_d;
  logic                      rx_ovr_q, rx_ovr_d, tx_ovr_q, tx_ovr_d;
  logic                      irq_en_q, irq_en_d;
  logic [15:0]               term_q, term_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      io_we_q, io_we_d, rx_irq_q, rx_irq_d;
  logic [7:0]                io_char_q, io_char_d;
  logic                      lpbk;

  logic [13:0] woff, roff;
  logic        wr_tx, wr_st, wr_ctrl, wr_term, rd_rx;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        drain_go, rx_push_req, rx_pop, rx_acc;
  logic [7:0]  tx_head, rx_head, rx_push_data;
  logic [RX_DEPTH_LOG:0] rx_cnt;
  logic [31:0] status;

  // Offsets wrap modulo 2^14, so anything below ADR_BASE lands far out of range.
  assign woff    = io_wadr - ADR_BASE;
  assign roff    = io_radr - ADR_BASE;
  assign wr_tx   = io_we && (woff == 14'd0);
  assign wr_st   = io_we && (woff == 14'd2);
  assign wr_ctrl = io_we && (woff == 14'd3);
  assign wr_term = io_we && (woff == 14'd4);
  assign rd_rx   = io_re && (roff == 14'd1);

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[TX_DEPTH_LOG] != tx_rp_q[TX_DEPTH_LOG]) &&
                    (tx_wp_q[TX_DEPTH_LOG-1:0] == tx_rp_q[TX_DEPTH_LOG-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[RX_DEPTH_LOG] != rx_rp_q[RX_DEPTH_LOG]) &&
                    (rx_wp_q[RX_DEPTH_LOG-1:0] == rx_rp_q[RX_DEPTH_LOG-1:0]);
  assign tx_head  = tx_mem_q[tx_rp_q[TX_DEPTH_LOG-1:0]];
  assign rx_head  = rx_mem_q[rx_rp_q[RX_DEPTH_LOG-1:0]];
  assign rx_cnt   = rx_wp_q - rx_rp_q;

`ifdef UART_IO_LOOPBACK_EN
  logic lpbk_q, lpbk_d;
  assign lpbk   = lpbk_q;
  assign lpbk_d = wr_ctrl ? io_wdata[2] : lpbk_q;
  always_ff @(posedge clk) begin
    if (rst) lpbk_q <= 1'b0;
    else     lpbk_q <= lpbk_d;
  end
`else
  assign lpbk = 1'b0;
`endif

  // Uart-bound drain is throttled by its own strobe (one char per 2 cycles),
  // which covers the one-cycle lag of uart_io_full. Loopback only needs RX room.
  assign drain_go     = !tx_empty && (lpbk ? !rx_full : (!uart_io_full && !io_we_q));
  assign rx_push_req  = lpbk ? drain_go : (rout_en && cpu_run_state);
  assign rx_push_data = lpbk ? tx_head : rout;
  assign rx_pop       = rd_rx && !rx_empty;
  assign rx_acc       = rx_push_req && (!rx_full || rx_pop);

  always_comb begin
    status                        = '0;
    status[0]                     = !rx_empty;
    status[1]                     = tx_full;
    status[2]                     = tx_empty;
    status[3]                     = rx_ovr_q;
    status[4]                     = tx_ovr_q;
    status[8 +: RX_DEPTH_LOG+1]   = rx_cnt;
  end

  always_comb begin
    tx_wp_d   = tx_wp_q;
    tx_rp_d   = tx_rp_q;
    rx_wp_d   = rx_wp_q;
    rx_rp_d   = rx_rp_q;
    tx_mem_d  = tx_mem_q;
    rx_mem_d  = rx_mem_q;
    rx_ovr_d  = rx_ovr_q;
    tx_ovr_d  = tx_ovr_q;
    irq_en_d  = irq_en_q;
    term_d    = term_q;
    rdata_d   = '0;
    io_we_d   = drain_go && !lpbk;
    io_char_d = io_char_q;
    rx_irq_d  = !rx_empty && irq_en_q;

    // TX push: a full FIFO drops the byte even if a drain happens this cycle.
    if (wr_tx) begin
      if (!tx_full) begin
        tx_mem_d[tx_wp_q[TX_DEPTH_LOG-1:0]] = io_wdata[7:0];
        tx_wp_d = tx_wp_q + 1'b1;
      end
    end
    if (drain_go) begin
      tx_rp_d = tx_rp_q + 1'b1;
      if (!lpbk) io_char_d = tx_head;
    end

    // RX: a pop in the same cycle frees the slot a full-FIFO push writes into.
    if (rx_acc) begin
      rx_mem_d[rx_wp_q[RX_DEPTH_LOG-1:0]] = rx_push_data;
      rx_wp_d = rx_wp_q + 1'b1;
    end
    if (rx_pop) rx_rp_d = rx_rp_q + 1'b1;

    // Sticky flags: clear first so a same-cycle set event wins.
    if (wr_st && io_wdata[3]) rx_ovr_d = 1'b0;
    if (wr_st && io_wdata[4]) tx_ovr_d = 1'b0;
    if (rx_push_req && rx_full && !rx_pop) rx_ovr_d = 1'b1;
    if (wr_tx && tx_full)                  tx_ovr_d = 1'b1;

    if (wr_ctrl) irq_en_d = io_wdata[0];
    if (wr_term) term_d   = io_wdata[15:0];

    if (io_re) begin
      case (roff)
        14'd1:   rdata_d = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head};
        14'd2:   rdata_d = status;
        14'd3:   rdata_d = {29'd0, lpbk, 1'b0, irq_en_q};
        14'd4:   rdata_d = {16'd0, term_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_ovr_q  <= 1'b0;
      tx_ovr_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      term_q    <= TERM_DEF;
      rdata_q   <= '0;
      io_we_q   <= 1'b0;
      io_char_q <= '0;
      rx_irq_q  <= 1'b0;
    end else begin
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      rx_ovr_q  <= rx_ovr_d;
      tx_ovr_q  <= tx_ovr_d;
      irq_en_q  <= irq_en_d;
      term_q    <= term_d;
      rdata_q   <= rdata_d;
      io_we_q   <= io_we_d;
      io_char_q <= io_char_d;
      rx_irq_q  <= rx_irq_d;
    end
  end

  // Storage needs no reset: contents are only visible between the pointers.
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  assign io_rdata     = rdata_q;
  assign uart_io_we   = io_we_q;
  assign uart_io_char = io_char_q;
  assign uart_term    = term_q;
  assign rx_irq       = rx_irq_q;
endmodule

// File: tb/tb_uart_io_regs.sv
module tb_uart_io_regs;
  localparam logic [13:0] BASE = 14'h3E00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_we = 1'b0, io_re = 1'b0;
  logic [13:0] io_wadr = '0, io_radr = '0;
  logic [31:0] io_wdata = '0;
  logic [31:0] io_rdata;
  logic        cpu_run_state = 1'b0, rout_en = 1'b0, uart_io_full = 1'b0;
  logic [7:0]  rout = '0;
  logic [7:0]  uart_io_char;
  logic        uart_io_we, rx_irq;
  logic [15:0] uart_term;

  int nvec = 0, nerr = 0, cyc = 0;
  logic [7:0] sq_ch [$];
  int         sq_cy [$];
  logic [31:0] rv;
  int base_n;

  uart_io_regs dut (
    .clk(clk), .rst(rst), .io_we(io_we), .io_wadr(io_wadr), .io_wdata(io_wdata),
    .io_re(io_re), .io_radr(io_radr), .io_rdata(io_rdata),
    .cpu_run_state(cpu_run_state), .rout_en(rout_en), .rout(rout),
    .uart_io_char(uart_io_char), .uart_io_we(uart_io_we), .uart_io_full(uart_io_full),
    .uart_term(uart_term), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Strobe log, sampled mid-cycle.
  always @(negedge clk) if (uart_io_we) begin
    sq_ch.push_back(uart_io_char);
    sq_cy.push_back(cyc);
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [13:0] off, input logic [31:0] d);
    io_we = 1'b1; io_wadr = BASE + off; io_wdata = d;
    tick();
    io_we = 1'b0;
  endtask

  task automatic rd(input logic [13:0] off, output logic [31:0] d);
    io_re = 1'b1; io_radr = BASE + off;
    tick();
    io_re = 1'b0;
    d = io_rdata;
  endtask

  task automatic rx_pulse(input logic [7:0] c);
    rout_en = 1'b1; rout = c;
    tick();
    rout_en = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_rdata", io_rdata, 32'd0);
    chk("rst_we", {31'd0, uart_io_we}, 32'd0);
    chk("rst_irq", {31'd0, rx_irq}, 32'd0);
    chk("rst_term_port", {16'd0, uart_term}, 32'd434);
    rd(4, rv); chk("rst_term_rd", rv, 32'h1B2);
    rd(2, rv); chk("rst_status", rv, 32'h004);
    tick(); chk("rdata_idle_zero", io_rdata, 32'd0);
    rd(7, rv); chk("unmapped_rd", rv, 32'd0);
    rd(14'h3FFF, rv); chk("below_base_rd", rv, 32'd0);

    // TX drain of two chars
    wr(0, 32'h41); wr(0, 32'h42);
    repeat (6) tick();
    chk("tx_strobes", sq_ch.size(), 2);
    if (sq_ch.size() == 2) begin
      chk("tx_ch0", {24'd0, sq_ch[0]}, 32'h41);
      chk("tx_ch1", {24'd0, sq_ch[1]}, 32'h42);
      chk("tx_gap_ge2", {31'd0, (sq_cy[1] - sq_cy[0]) >= 2}, 32'd1);
    end

    // TX overflow under full back-pressure
    uart_io_full = 1'b1;
    base_n = sq_ch.size();
    for (int i = 1; i <= 5; i++) wr(0, i);
    repeat (3) tick();
    chk("no_strobe_full", sq_ch.size(), base_n);
    rd(2, rv); chk("status_txfull_ovr", rv, 32'h012);
    uart_io_full = 1'b0;
    repeat (12) tick();
    chk("tx_drain4", sq_ch.size(), base_n + 4);
    for (int i = 0; i < 4; i++)
      if (sq_ch.size() > base_n + i) chk("tx_drain_ch", {24'd0, sq_ch[base_n+i]}, i + 1);
    wr(2, 32'h10);
    rd(2, rv); chk("status_txovr_clr", rv, 32'h004);

    // RX capture with overflow
    cpu_run_state = 1'b1;
    for (int i = 0; i < 9; i++) rx_pulse(8'h30 + i[7:0]);
    rd(2, rv); chk("status_rx_full_ovr", rv, 32'h80D);
    for (int i = 0; i < 8; i++) begin
      rd(1, rv); chk("rx_pop", rv, 32'h130 + i);
    end
    rd(1, rv); chk("rx_empty_rd", rv, 32'h000);
    rd(2, rv); chk("status_rxovr_set", rv, 32'h00C);
    wr(2, 32'h08);
    rd(2, rv); chk("status_rxovr_clr", rv, 32'h004);

    // RX ignored while CPU halted
    cpu_run_state = 1'b0;
    rx_pulse(8'h55);
    rd(2, rv); chk("rx_halted_ignored", rv, 32'h004);

    // RX interrupt
    cpu_run_state = 1'b1;
    wr(3, 32'h1);
    rx_pulse(8'h7A);
    chk("irq_lag", {31'd0, rx_irq}, 32'd0);
    tick();
    chk("irq_rise", {31'd0, rx_irq}, 32'd1);
    rd(1, rv); chk("irq_rxdata", rv, 32'h17A);
    tick();
    chk("irq_fall", {31'd0, rx_irq}, 32'd0);

    // TERM write and reset mid-operation
    wr(4, 32'hABCD_1234);
    chk("term_port", {16'd0, uart_term}, 32'h1234);
    rx_pulse(8'h11); rx_pulse(8'h22);
    uart_io_full = 1'b1;
    wr(0, 32'h66); wr(0, 32'h77);
    base_n = sq_ch.size();
    rst = 1'b1; tick(); rst = 1'b0;
    uart_io_full = 1'b0;
    chk("midrst_term", {16'd0, uart_term}, 32'd434);
    rd(2, rv); chk("midrst_status", rv, 32'h004);
    repeat (6) tick();
    chk("midrst_no_strobe", sq_ch.size(), base_n);
    rd(3, rv); chk("midrst_ctrl", rv, 32'h0);

`ifdef UART_IO_LOOPBACK_EN
    wr(3, 32'h5);
    rd(3, rv); chk("lb_ctrl", rv, 32'h5);
    base_n = sq_ch.size();
    wr(0, 32'h99);
    repeat (4) tick();
    chk("lb_no_strobe", sq_ch.size(), base_n);
    rd(1, rv); chk("lb_rxdata", rv, 32'h199);
`else
    wr(3, 32'h5);
    rd(3, rv); chk("ctrl_no_lb", rv, 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
